// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared exception codes, STATUS bit indices, FSM encoding and priority helper
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_ERL    = 2;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int STATUS_BEV    = 22;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_EXL = 2'd2
    } exc_state_e;

    // Int > RI > Sys > Bp > Ov; callers only use the result when some source is set.
    function automatic logic [4:0] exc_prio(input logic int_take, input logic ri,
                                            input logic sys, input logic brk);
        logic [4:0] code;
        if (int_take)  code = EXC_INT;
        else if (ri)   code = EXC_RI;
        else if (sys)  code = EXC_SYS;
        else if (brk)  code = EXC_BP;
        else           code = EXC_OV;
        return code;
    endfunction

endpackage

// File: rtl/exc_ctrl_cp0_timer.sv
// rtl/exc_ctrl_cp0_timer.sv - COUNT/COMPARE timer with pending flag (used when EXC_CTRL_TIMER_EN is defined)
module cp0_timer
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_wr,
    input  logic        cmp_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_flag
);

    logic        half_q, half_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;
    logic        inc;

    always_comb begin
        half_d    = ~half_q;
        inc       = half_q;
        count_d   = count_q;
        compare_d = compare_q;
        flag_d    = flag_q;
        if (cnt_wr)
            count_d = wr_data;
        else if (inc)
            count_d = count_q + 32'd1;
        if (cmp_wr) begin
            compare_d = wr_data;
            flag_d    = 1'b0;
        end else if (inc && !cnt_wr && (count_d == compare_q)) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            flag_q    <= 1'b0;
        end else begin
            half_q    <= half_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
        end
    end

    assign count      = count_q;
    assign compare    = compare_q;
    assign timer_flag = flag_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt front end for CP0; EXC_CTRL_TIMER_EN enables the COUNT/COMPARE timer
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_NORMAL  = 32'h0000_3000,
    parameter logic [31:0] VEC_BOOT    = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  hw_int,
    input  logic [1:0]  sw_ip,
    input  logic [31:0] status,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic        ex_ri,
    input  logic        ex_sys,
    input  logic        ex_brk,
    input  logic        ex_ov,
    input  logic        cmp_wr,
    input  logic        cnt_wr,
    input  logic [31:0] wr_data,
    output logic        exc_valid,
    input  logic        exc_ready,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic [31:0] exc_vector,
    output logic [7:0]  ip_pending,
    output logic [31:0] count_out,
    output logic [31:0] compare_out
);

    logic [5:0]  sync_q [SYNC_STAGES];
    logic [5:0]  sync_d [SYNC_STAGES];
    logic [7:0]  ip_pending_q, ip_pending_d;
    exc_state_e  state_q, state_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_epc_q, exc_epc_d;
    logic        exc_bd_q, exc_bd_d;
    logic [31:0] exc_vector_q, exc_vector_d;
    logic        timer_flag;
    logic        int_take;
    logic        any_src;
    logic        unused_status;

`ifdef EXC_CTRL_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_wr     (cnt_wr),
        .cmp_wr     (cmp_wr),
        .wr_data    (wr_data),
        .count      (count_out),
        .compare    (compare_out),
        .timer_flag (timer_flag)
    );
`else
    logic unused_timer;
    assign unused_timer = ^{cmp_wr, cnt_wr, wr_data};
    assign timer_flag   = 1'b0;
    assign count_out    = '0;
    assign compare_out  = '0;
`endif

    assign unused_status = ^{status[31:23], status[21:16], status[7:3]};

    always_comb begin
        sync_d[0] = hw_int;
        for (int i = 1; i < SYNC_STAGES; i++)
            sync_d[i] = sync_q[i-1];
        ip_pending_d = {sync_q[SYNC_STAGES-1][5] | timer_flag,
                        sync_q[SYNC_STAGES-1][4:0], sw_ip};
    end

    assign int_take = (|(ip_pending_q & status[STATUS_IM_HI:STATUS_IM_LO]))
                    && status[STATUS_IE] && !status[STATUS_EXL] && !status[STATUS_ERL];
    assign any_src  = int_take || ex_ri || ex_sys || ex_brk || ex_ov;

    always_comb begin
        state_d      = state_q;
        exc_valid_d  = exc_valid_q;
        exc_code_d   = exc_code_q;
        exc_epc_d    = exc_epc_q;
        exc_bd_d     = exc_bd_q;
        exc_vector_d = exc_vector_q;
        case (state_q)
            ST_IDLE: begin
                // Only a committing instruction supplies a precise EPC, so nothing is taken without one.
                if (commit_valid && any_src) begin
                    state_d      = ST_REQ;
                    exc_valid_d  = 1'b1;
                    exc_code_d   = exc_prio(int_take, ex_ri, ex_sys, ex_brk);
                    exc_epc_d    = commit_bd ? (commit_pc - 32'd4) : commit_pc;
                    exc_bd_d     = commit_bd;
                    exc_vector_d = status[STATUS_BEV] ? VEC_BOOT : VEC_NORMAL;
                end
            end
            ST_REQ: begin
                if (exc_ready) begin
                    state_d      = ST_WAIT_EXL;
                    exc_valid_d  = 1'b0;
                    exc_code_d   = '0;
                    exc_epc_d    = '0;
                    exc_bd_d     = 1'b0;
                    exc_vector_d = '0;
                end
            end
            ST_WAIT_EXL: begin
                if (status[STATUS_EXL] || status[STATUS_ERL])
                    state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                exc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            ip_pending_q <= '0;
            state_q      <= ST_IDLE;
            exc_valid_q  <= 1'b0;
            exc_code_q   <= '0;
            exc_epc_q    <= '0;
            exc_bd_q     <= 1'b0;
            exc_vector_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_d[i];
            ip_pending_q <= ip_pending_d;
            state_q      <= state_d;
            exc_valid_q  <= exc_valid_d;
            exc_code_q   <= exc_code_d;
            exc_epc_q    <= exc_epc_d;
            exc_bd_q     <= exc_bd_d;
            exc_vector_q <= exc_vector_d;
        end
    end

    assign exc_valid  = exc_valid_q;
    assign exc_code   = exc_code_q;
    assign exc_epc    = exc_epc_q;
    assign exc_bd     = exc_bd_q;
    assign exc_vector = exc_vector_q;
    assign ip_pending = ip_pending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic [1:0]  sw_ip;
    logic [31:0] status;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        ex_ri, ex_sys, ex_brk, ex_ov;
    logic        cmp_wr, cnt_wr;
    logic [31:0] wr_data;
    logic        exc_valid;
    logic        exc_ready;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic [31:0] exc_vector;
    logic [7:0]  ip_pending;
    logic [31:0] count_out, compare_out;

    int total = 0;
    int bad   = 0;
    int n;
    logic [31:0] saved_status;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hw_int       (hw_int),
        .sw_ip        (sw_ip),
        .status       (status),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_bd    (commit_bd),
        .ex_ri        (ex_ri),
        .ex_sys       (ex_sys),
        .ex_brk       (ex_brk),
        .ex_ov        (ex_ov),
        .cmp_wr       (cmp_wr),
        .cnt_wr       (cnt_wr),
        .wr_data      (wr_data),
        .exc_valid    (exc_valid),
        .exc_ready    (exc_ready),
        .exc_code     (exc_code),
        .exc_epc      (exc_epc),
        .exc_bd       (exc_bd),
        .exc_vector   (exc_vector),
        .ip_pending   (ip_pending),
        .count_out    (count_out),
        .compare_out  (compare_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_commit();
        commit_valid = 1'b0;
        commit_bd    = 1'b0;
        ex_ri = 1'b0; ex_sys = 1'b0; ex_brk = 1'b0; ex_ov = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic bd,
                             input logic ri, input logic sys, input logic brk, input logic ov);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_bd    = bd;
        ex_ri = ri; ex_sys = sys; ex_brk = brk; ex_ov = ov;
        tick();
        clear_commit();
    endtask

    task automatic accept(input string tag);
        exc_ready = 1'b1;
        tick();
        exc_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, exc_valid}, 32'd0);
        saved_status = status;
        status = saved_status | 32'h2;
        tick();
        status = saved_status;
    endtask

    initial begin
        rst_n = 1'b0;
        hw_int = '0; sw_ip = '0; status = '0;
        commit_pc = '0; exc_ready = 1'b0;
        cmp_wr = 1'b0; cnt_wr = 1'b0; wr_data = '0;
        clear_commit();
        tick(); tick();
        chk("rst_valid",   {31'd0, exc_valid}, 32'd0);
        chk("rst_code",    {27'd0, exc_code}, 32'd0);
        chk("rst_epc",     exc_epc, 32'd0);
        chk("rst_vector",  exc_vector, 32'd0);
        chk("rst_ip",      {24'd0, ip_pending}, 32'd0);
        chk("rst_count",   count_out, 32'd0);
        chk("rst_compare", compare_out, 32'd0);
        rst_n = 1'b1;
        tick();

        // Sys exception, BEV=0
        status = 32'h1;
        do_commit(32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sys_valid",  {31'd0, exc_valid}, 32'd1);
        chk("sys_code",   {27'd0, exc_code}, 32'd8);
        chk("sys_epc",    exc_epc, 32'h100);
        chk("sys_bd",     {31'd0, exc_bd}, 32'd0);
        chk("sys_vector", exc_vector, 32'h0000_3000);
        tick(); tick();
        chk("sys_hold_valid", {31'd0, exc_valid}, 32'd1);
        chk("sys_hold_code",  {27'd0, exc_code}, 32'd8);
        accept("sys");

        // Ov in delay slot with BEV=1
        status = 32'h0040_0000;
        do_commit(32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ov_code",   {27'd0, exc_code}, 32'd12);
        chk("ov_epc",    exc_epc, 32'h200);
        chk("ov_bd",     {31'd0, exc_bd}, 32'd1);
        chk("ov_vector", exc_vector, 32'hBFC0_0380);
        accept("ov");

        // EPC wrap below zero
        status = 32'h1;
        do_commit(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_code", {27'd0, exc_code}, 32'd9);
        chk("wrap_epc",  exc_epc, 32'hFFFF_FFFC);
        accept("wrap");

        // Priority among synchronous sources
        do_commit(32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio_ri", {27'd0, exc_code}, 32'd10);
        accept("prio_ri");
        do_commit(32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("prio_sys", {27'd0, exc_code}, 32'd8);
        accept("prio_sys");
        do_commit(32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("prio_bp", {27'd0, exc_code}, 32'd9);
        accept("prio_bp");

        // Interrupt beats RI after sync latency (2 sync flops + ip register)
        status = 32'h401;
        hw_int = 6'b000001;
        tick(); tick();
        chk("ip_not_yet", {24'd0, ip_pending}, 32'h00);
        tick();
        chk("ip_sync", {24'd0, ip_pending}, 32'h04);
        do_commit(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("int_valid", {31'd0, exc_valid}, 32'd1);
        chk("int_code",  {27'd0, exc_code}, 32'd0);
        chk("int_epc",   exc_epc, 32'h300);
        accept("int");

        // Masking cases with hw_int[0] still asserted
        status = 32'h403;
        do_commit(32'h320, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_exl_valid", {31'd0, exc_valid}, 32'd0);
        chk("mask_exl_ip",    {31'd0, ip_pending[2]}, 32'd1);
        status = 32'h405;
        do_commit(32'h324, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_erl_valid", {31'd0, exc_valid}, 32'd0);
        status = 32'h400;
        do_commit(32'h328, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_ie_valid", {31'd0, exc_valid}, 32'd0);
        status = 32'h801;
        do_commit(32'h32C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_im_valid", {31'd0, exc_valid}, 32'd0);
        status = 32'h401;
        tick();
        chk("no_commit_valid", {31'd0, exc_valid}, 32'd0);
        hw_int = '0;
        tick(); tick(); tick();

        // Software interrupt path
        sw_ip  = 2'b10;
        status = 32'h201;
        tick();
        chk("sw_ip", {24'd0, ip_pending}, 32'h02);
        do_commit(32'h340, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sw_int_code", {27'd0, exc_code}, 32'd0);
        chk("sw_int_valid", {31'd0, exc_valid}, 32'd1);
        sw_ip = '0;
        accept("sw_int");
        tick();

        // Handshake gating: hold, ignore new sources, wait for EXL
        status = 32'h1;
        do_commit(32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        commit_valid = 1'b1; commit_pc = 32'h600; ex_ri = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {31'd0, exc_valid}, 32'd1);
            chk("hold_code",  {27'd0, exc_code}, 32'd8);
            chk("hold_epc",   exc_epc, 32'h500);
        end
        clear_commit();
        exc_ready = 1'b1;
        tick();
        exc_ready = 1'b0;
        chk("gate_drop", {31'd0, exc_valid}, 32'd0);
        commit_valid = 1'b1; commit_pc = 32'h640; ex_sys = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gate_no_reissue", {31'd0, exc_valid}, 32'd0);
        end
        clear_commit();
        status = 32'h3;
        tick();
        status = 32'h1;
        do_commit(32'h700, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("gate_reissue_valid", {31'd0, exc_valid}, 32'd1);
        chk("gate_reissue_code",  {27'd0, exc_code}, 32'd9);
        chk("gate_reissue_epc",   exc_epc, 32'h700);

        // Asynchronous reset while a request is pending
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, exc_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_commit(32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_code", {27'd0, exc_code}, 32'd12);
        accept("post_rst");

        status = 32'h0;
`ifdef EXC_CTRL_TIMER_EN
        cnt_wr = 1'b1; wr_data = 32'hFFFF_FFFE;
        tick();
        cnt_wr = 1'b0;
        chk("tmr_count_load", count_out, 32'hFFFF_FFFE);
        cmp_wr = 1'b1; wr_data = 32'h1;
        tick();
        cmp_wr = 1'b0;
        chk("tmr_compare_load", compare_out, 32'h1);
        n = 0;
        while (ip_pending[7] !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk("tmr_flag_seen", {31'd0, ip_pending[7]}, 32'd1);
        chk("tmr_count_at_flag", count_out, 32'h1);
        chk("tmr_no_request", {31'd0, exc_valid}, 32'd0);
        cmp_wr = 1'b1; wr_data = 32'h1;
        tick();
        cmp_wr = 1'b0;
        tick();
        chk("tmr_flag_clear", {31'd0, ip_pending[7]}, 32'd0);
`else
        cnt_wr = 1'b1; wr_data = 32'hFFFF_FFFE;
        tick();
        cnt_wr = 1'b0;
        cmp_wr = 1'b1; wr_data = 32'h1;
        tick();
        cmp_wr = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick(); tick();
        chk("notmr_count",   count_out, 32'd0);
        chk("notmr_compare", compare_out, 32'd0);
        chk("notmr_ip",      {24'd0, ip_pending}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt front end sitting directly upstream of coprocessor 0.
- Synchronises hardware interrupt lines and runs the optional COUNT/COMPARE timer.
- Prioritises interrupt and synchronous exception sources at the commit point.
- Presents one exception request at a time to CP0/pipeline over a valid/ready handshake, with cause code, EPC, branch-delay flag and vector address.

Parameters:
- VEC_NORMAL, 32'h0000_3000, exception vector when BEV=0
- VEC_BOOT, 32'hBFC0_0380, exception vector when BEV=1
- SYNC_STAGES, 2, flip-flop depth of the hw_int synchroniser (minimum 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hw_int  in  6  raw external interrupt lines, level-sensitive, map to IP[7:2]
- sw_ip  in  2  software interrupt bits CAUSE.IP[1:0] from CP0
- status  in  32  CP0 STATUS: IM=[15:8], BEV=22, UM=4, ERL=2, EXL=1, IE=0
- commit_valid  in  1  an instruction is at the commit point this cycle
- commit_pc  in  32  PC of the committing instruction
- commit_bd  in  1  committing instruction is in a branch-delay slot
- ex_ri, ex_sys, ex_brk, ex_ov  in  1 each  synchronous exception flags for the committing instruction
- cmp_wr  in  1  mtc0 to COMPARE this cycle
- cnt_wr  in  1  mtc0 to COUNT this cycle
- wr_data  in  32  mtc0 write data
- exc_valid  out  1  exception request pending
- exc_ready  in  1  CP0/pipeline accepts the request
- exc_code  out  5  CAUSE.ExcCode: Int=0, Sys=8, Bp=9, RI=10, Ov=12
- exc_epc  out  32  value for EPC
- exc_bd  out  1  value for CAUSE.BD
- exc_vector  out  32  target PC
- ip_pending  out  8  live CAUSE.IP[7:0]
- count_out, compare_out  out  32 each  timer registers for mfc0 readback

Behaviour:
- Reset: all outputs and registers are 0, including the synchroniser chain and timer; state IDLE.
- hw_int passes through a SYNC_STAGES-flop chain. ip_pending = {sync_hw[5:0], sw_ip}, registered, 1 cycle after sync.
- Interrupt taken when: (ip_pending & status[15:8]) != 0, status[0]=1, status[1]=0, status[2]=0.
- Priority per committing instruction: Int > RI > Sys > Bp > Ov. Exactly one code is reported.
- State IDLE:
  - On commit_valid with any taken source: latch code, epc, bd and vector; go to REQ.
  - Without commit_valid, interrupts are not taken, because no precise PC is available.
- State REQ:
  - exc_valid=1; exc_code, exc_epc, exc_bd and exc_vector are held stable until the cycle with exc_ready=1.
  - On exc_ready: go to WAIT_EXL; exc_valid drops the next cycle.
- State WAIT_EXL: no new request accepted until status[1]=1 or status[2]=1 is observed, then return to IDLE. This prevents double issue before CP0 updates STATUS.
- EPC: commit_bd=1 gives epc = commit_pc - 4 (32-bit wrap) and bd=1; otherwise epc = commit_pc and bd=0.
- Vector: status[22]=1 selects VEC_BOOT, else VEC_NORMAL, sampled at latch time.
- New sources arriving while in REQ or WAIT_EXL are ignored, not queued. Interrupt levels stay visible in ip_pending.
- Reset asserted mid-REQ: immediate return to IDLE, exc_valid=0.

Optional Feature:
- Macro: EXC_CTRL_TIMER_EN.
- Defined:
  - COUNT increments every second clk.
  - cnt_wr loads COUNT; cmp_wr loads COMPARE and clears the timer pending flag.
  - COUNT==COMPARE, checked after increment, sets the timer flag, which is ORed into ip_pending[7].
  - cnt_wr has priority over the increment in the same cycle; COUNT wraps 0xFFFFFFFF to 0.
- Not defined: count_out and compare_out are tied to 0, cmp_wr and cnt_wr are ignored, ip_pending[7] = sync_hw[5] only.

Decomposition:
- Shared package: ExcCode constants (EXC_INT, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), STATUS/CAUSE bit-index constants, state encoding.
- Sub-module: cp0_timer (COUNT/COMPARE, timer flag), instantiated only under EXC_CTRL_TIMER_EN.

Test Plan:
- Sys exception:
  - Stimulus: status=0x1, commit_valid, commit_pc=0x100, ex_sys=1.
  - Response: exc_valid next cycle; code=8, epc=0x100, bd=0, vector=0x3000. Held until exc_ready; cleared after.
- Delay slot with BEV:
  - Stimulus: ex_ov=1, commit_bd=1, commit_pc=0x204, status[22]=1.
  - Response: code=12, epc=0x200, bd=1, vector=0xBFC00380.
- Interrupt priority:
  - Stimulus: hw_int[0]=1, status=0x401 (IM2, IE), ex_ri=1 in the same commit.
  - Response: code=0 after sync latency; RI suppressed.
- Masking:
  - Stimulus: hw_int[0]=1 with status=0x403 (EXL=1).
  - Response: no request; ip_pending[2]=1.
- Handshake gating:
  - Stimulus: exc_ready held low for 5 cycles, then pulsed; status[1] kept 0 for 3 cycles.
  - Response: outputs stable throughout; no second exc_valid until EXL is seen.
- Timer (EXC_CTRL_TIMER_EN):
  - Stimulus: cnt_wr 0xFFFFFFFE, cmp_wr 0x1.
  - Response: wrap through 0; ip_pending[7]=1 about 6 cycles later. A second cmp_wr clears it.
